// File: rtl/noc_phase_sequencer.sv
// Lock-step network sequencer: steps all routers through LOAD_STAGING and PHASES
// compute phases per network cycle, routing data flits forward and credits backward.
module noc_phase_sequencer #(
    parameter int NUM_ROUTERS = 4,
    parameter int NUM_PORTS   = 4,
    parameter int FLIT_W      = 32,
    parameter int OP_W        = 3,
    parameter int PHASES      = 2,
    parameter int CYCLE_W     = 32,
    localparam int RB = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1,
    localparam int PB = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    stop,
    input  logic [CYCLE_W-1:0]                      max_cycles,
    input  logic                                    cfg_we,
    input  logic [RB-1:0]                           cfg_src_router,
    input  logic [PB-1:0]                           cfg_src_port,
    input  logic [RB-1:0]                           cfg_dst_router,
    input  logic [PB-1:0]                           cfg_dst_port,
    input  logic                                    cfg_valid,
    input  logic [NUM_ROUTERS-1:0]                  router_done,
    input  logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0] out_staging,
    input  logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0] out_cr_staging,
    output logic [NUM_ROUTERS*OP_W-1:0]             op,
    output logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0] in_staging,
    output logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0] in_cr_staging,
    output logic [CYCLE_W-1:0]                      in_cycle,
    output logic                                    busy,
    output logic                                    finished
);

    localparam int N   = NUM_ROUTERS * NUM_PORTS;
    localparam int NB  = (N > 1) ? $clog2(N) : 1;
    localparam int PHB = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PHB-1:0]     PH_LAST = PHB'(PHASES - 1);
    localparam logic [OP_W-1:0]    OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0]    OP_LOAD = OP_W'(1);
    localparam logic [OP_W-1:0]    OP_PH0  = OP_W'(2);
    localparam logic [CYCLE_W-1:0] CYC_ONE = CYCLE_W'(1);
    localparam logic [CYCLE_W-1:0] CYC_ZERO = CYCLE_W'(0);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PHASE, ST_DONE} state_t;

    state_t              state_r, state_s;
    logic [PHB-1:0]      phase_r, phase_s;
    logic [OP_W-1:0]     op_r, op_s;
    logic                busy_r, busy_s, finished_r, finished_s;
    logic                stop_r;
    logic [CYCLE_W-1:0]  in_cycle_r, cycle_inc_s;
    logic                idle_s, last_phase_s, term_s, cfg_en_s, run_start_s;
    logic [NB-1:0]       cfg_src_idx_s, cfg_dst_idx_s;

    logic                link_valid_r [N];
    logic [NB-1:0]       link_dst_r   [N];
    logic [FLIT_W-1:0]   out_data_s   [N];
    logic [FLIT_W-1:0]   out_cr_s     [N];
    logic [FLIT_W-1:0]   route_data_s [N];
    logic [FLIT_W-1:0]   route_cr_s   [N];
    logic [FLIT_W-1:0]   in_data_r    [N];
    logic [FLIT_W-1:0]   in_cr_r      [N];

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign out_data_s[g] = out_staging[g*FLIT_W +: FLIT_W];
        assign out_cr_s[g]   = out_cr_staging[g*FLIT_W +: FLIT_W];
        assign in_staging[g*FLIT_W +: FLIT_W]    = in_data_r[g];
        assign in_cr_staging[g*FLIT_W +: FLIT_W] = in_cr_r[g];
    end

    for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_op
        assign op[g*OP_W +: OP_W] = op_r;
    end

    assign in_cycle = in_cycle_r;
    assign busy     = busy_r;
    assign finished = finished_r;

    // Control decodes: run start, final phase, termination and gated config writes
    always_comb begin
        idle_s        = (state_r == ST_IDLE) || (state_r == ST_DONE);
        run_start_s   = idle_s && start;
        last_phase_s  = (state_r == ST_PHASE) && (phase_r == PH_LAST);
        cycle_inc_s   = in_cycle_r + CYC_ONE;
        // A stop raised in the final phase itself still ends this network cycle
        term_s        = (&router_done) || stop_r || stop ||
                        ((max_cycles != CYC_ZERO) && (cycle_inc_s == max_cycles));
        cfg_en_s      = cfg_we && idle_s &&
                        (int'(cfg_src_router) < NUM_ROUTERS) && (int'(cfg_src_port) < NUM_PORTS) &&
                        (int'(cfg_dst_router) < NUM_ROUTERS) && (int'(cfg_dst_port) < NUM_PORTS);
        cfg_src_idx_s = NB'(int'(cfg_src_router) * NUM_PORTS + int'(cfg_src_port));
        cfg_dst_idx_s = NB'(int'(cfg_dst_router) * NUM_PORTS + int'(cfg_dst_port));
    end

    // Next-state and next-output logic
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        op_s       = OP_NOP;
        busy_s     = 1'b0;
        finished_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                state_s = ST_PHASE;
                phase_s = {PHB{1'b0}};
            end
            ST_PHASE: begin
                if (phase_r == PH_LAST) begin
                    state_s = term_s ? ST_DONE : ST_LOAD;
                    phase_s = {PHB{1'b0}};
                end else begin
                    phase_s = phase_r + PHB'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = {PHB{1'b0}};
            end
        endcase
        case (state_s)
            ST_LOAD:  begin op_s = OP_LOAD;                  busy_s = 1'b1; end
            ST_PHASE: begin op_s = OP_PH0 + OP_W'(phase_s); busy_s = 1'b1; end
            ST_DONE:  begin finished_s = 1'b1; end
            default:  begin op_s = OP_NOP; end
        endcase
    end

    // Link routing: later (higher flat index) sources overwrite earlier ones on collision
    always_comb begin
        for (int d = 0; d < N; d++) begin
            route_data_s[d] = {FLIT_W{1'b0}};
            for (int s = 0; s < N; s++) begin
                route_data_s[d] = (link_valid_r[s] && (link_dst_r[s] == NB'(d))) ?
                                  out_data_s[s] : route_data_s[d];
            end
        end
        for (int s = 0; s < N; s++) begin
            route_cr_s[s] = link_valid_r[s] ? out_cr_s[link_dst_r[s]] : {FLIT_W{1'b0}};
        end
    end

    // State, outputs, stop latch and network cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            phase_r    <= {PHB{1'b0}};
            op_r       <= OP_NOP;
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
            stop_r     <= 1'b0;
            in_cycle_r <= CYC_ZERO;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            op_r       <= op_s;
            busy_r     <= busy_s;
            finished_r <= finished_s;
            if (run_start_s) begin
                stop_r <= 1'b0;
            end else if (!idle_s && stop) begin
                stop_r <= 1'b1;
            end else begin
                stop_r <= stop_r;
            end
            if (run_start_s) begin
                in_cycle_r <= CYC_ZERO;
            end else if (last_phase_s) begin
                in_cycle_r <= cycle_inc_s;
            end else begin
                in_cycle_r <= in_cycle_r;
            end
        end
    end

    // Link table and staging registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                link_valid_r[i] <= 1'b0;
                link_dst_r[i]   <= {NB{1'b0}};
                in_data_r[i]    <= {FLIT_W{1'b0}};
                in_cr_r[i]      <= {FLIT_W{1'b0}};
            end
        end else begin
            if (cfg_en_s) begin
                link_valid_r[cfg_src_idx_s] <= cfg_valid;
                link_dst_r[cfg_src_idx_s]   <= cfg_dst_idx_s;
            end
            if (state_r == ST_LOAD) begin
                for (int i = 0; i < N; i++) begin
                    in_data_r[i] <= route_data_s[i];
                    in_cr_r[i]   <= route_cr_s[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// Randomized self-checking bench for noc_phase_sequencer against a link-table/schedule model.
module tb_noc_phase_sequencer;
    localparam int R = 2, P = 2, W = 32, OPW = 3, PH = 2, CW = 16;
    localparam int N = R * P;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cfg_we = 1'b0, cfg_valid = 1'b0;
    logic [CW-1:0] max_cycles = '0;
    logic [0:0] cfg_src_router = '0, cfg_dst_router = '0, cfg_src_port = '0, cfg_dst_port = '0;
    logic [R-1:0] router_done = '0;
    logic [N*W-1:0] out_staging, out_cr_staging, in_staging, in_cr_staging;
    logic [R*OPW-1:0] op;
    logic [CW-1:0] in_cycle;
    logic busy, finished;

    logic [W-1:0] ob [N];
    logic [W-1:0] oc [N];
    bit           m_valid [N];
    int           m_dst [N];
    logic [N*W-1:0] exp_data, exp_cr;
    int m_cycle;
    int vectors = 0, miscompares = 0;

    noc_phase_sequencer #(.NUM_ROUTERS(R), .NUM_PORTS(P), .FLIT_W(W), .OP_W(OPW),
                          .PHASES(PH), .CYCLE_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .max_cycles(max_cycles),
        .cfg_we(cfg_we), .cfg_src_router(cfg_src_router), .cfg_src_port(cfg_src_port),
        .cfg_dst_router(cfg_dst_router), .cfg_dst_port(cfg_dst_port), .cfg_valid(cfg_valid),
        .router_done(router_done), .out_staging(out_staging), .out_cr_staging(out_cr_staging),
        .op(op), .in_staging(in_staging), .in_cr_staging(in_cr_staging),
        .in_cycle(in_cycle), .busy(busy), .finished(finished));

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_staging[i*W +: W]    = ob[i];
            out_cr_staging[i*W +: W] = oc[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_dst[i] = 0;
        end
        exp_data = '0;
        exp_cr = '0;
    endtask

    // Destination receives the data of the highest-indexed valid source that targets it
    task automatic model_route();
        exp_data = '0;
        exp_cr = '0;
        for (int d = 0; d < N; d++) begin
            bit found = 1'b0;
            for (int s = N - 1; s >= 0; s--) begin
                if (!found && m_valid[s] && m_dst[s] == d) begin
                    exp_data[d*W +: W] = ob[s];
                    found = 1'b1;
                end
            end
        end
        for (int s = 0; s < N; s++)
            if (m_valid[s]) exp_cr[s*W +: W] = oc[m_dst[s]];
    endtask

    task automatic cfg_write(input int sr, input int sp, input int dr, input int dp, input bit v);
        cfg_src_router = sr[0:0]; cfg_src_port = sp[0:0];
        cfg_dst_router = dr[0:0]; cfg_dst_port = dp[0:0];
        cfg_valid = v; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        m_valid[sr*P+sp] = v;
        m_dst[sr*P+sp] = dr*P + dp;
    endtask

    // One complete run from start to DONE, checked clock by clock
    task automatic run(input int maxc, input int done_at, input int stop_at, input int stop_mode,
                       input bit rnd, input bit busy_wr, output int clocks);
        bit term, stop_seen;
        logic [R-1:0] rd;
        logic [R*OPW-1:0] exp_op;
        term = 1'b0; stop_seen = 1'b0; m_cycle = 0;
        max_cycles = maxc[CW-1:0];
        start = 1'b1; tick(); start = 1'b0; clocks = 1;
        for (int k = 0; k < 40 && !term; k++) begin
            exp_op = {R{OPW'(1)}};
            vectors++;
            if (op !== exp_op || busy !== 1'b1 || finished !== 1'b0 || in_cycle !== m_cycle[CW-1:0]) begin
                $display("FAIL load_state cyc %0d: op=%h busy=%b fin=%b in_cycle=%0d, want op=%h busy=1 fin=0 in_cycle=%0d",
                         k, op, busy, finished, in_cycle, exp_op, m_cycle);
                miscompares++;
            end
            if (rnd) for (int i = 0; i < N; i++) begin ob[i] = $urandom; oc[i] = $urandom; end
            model_route();
            if (k == stop_at && stop_mode == 0) begin stop = 1'b1; stop_seen = 1'b1; end
            tick(); clocks++; stop = 1'b0;
            for (int ph = 0; ph < PH; ph++) begin
                exp_op = {R{OPW'(2 + ph)}};
                vectors++;
                if (op !== exp_op || busy !== 1'b1) begin
                    $display("FAIL phase_op cyc %0d ph %0d: op=%h busy=%b, want op=%h busy=1", k, ph, op, busy, exp_op);
                    miscompares++;
                end
                vectors++;
                if (in_staging !== exp_data || in_cr_staging !== exp_cr) begin
                    $display("FAIL routing cyc %0d ph %0d: data=%h cr=%h, want data=%h cr=%h",
                             k, ph, in_staging, in_cr_staging, exp_data, exp_cr);
                    miscompares++;
                end
                if (busy_wr && k == 0 && ph == 0) begin
                    cfg_src_router = 1'b0; cfg_src_port = 1'b0; cfg_dst_router = 1'b0;
                    cfg_dst_port = 1'b1; cfg_valid = 1'b1; cfg_we = 1'b1;
                end
                if (ph == PH - 1) begin
                    rd = $urandom;
                    if (&rd) rd[0] = 1'b0;
                    if (k == done_at) rd = '1;
                    router_done = rd;
                    if (k == stop_at && stop_mode == 1) begin stop = 1'b1; stop_seen = 1'b1; end
                    term = (k == done_at) || stop_seen || (maxc != 0 && k + 1 == maxc);
                end
                tick(); clocks++;
                cfg_we = 1'b0; stop = 1'b0; router_done = '0;
            end
            m_cycle++;
        end
        vectors++;
        if (!term) begin
            $display("FAIL run_timeout: no termination after %0d network cycles, want termination", m_cycle);
            miscompares++;
        end
        vectors++;
        if (finished !== 1'b1 || busy !== 1'b0 || op !== '0 || in_cycle !== m_cycle[CW-1:0]) begin
            $display("FAIL done_state: fin=%b busy=%b op=%h in_cycle=%0d, want fin=1 busy=0 op=0 in_cycle=%0d",
                     finished, busy, op, in_cycle, m_cycle);
            miscompares++;
        end
        vectors++;
        if (in_staging !== exp_data || in_cr_staging !== exp_cr) begin
            $display("FAIL staging_retained: data=%h cr=%h, want data=%h cr=%h", in_staging, in_cr_staging, exp_data, exp_cr);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        int c;
        vectors++;
        if (op !== '0 || busy !== 1'b0 || finished !== 1'b0 || in_cycle !== '0 || in_staging !== '0 || in_cr_staging !== '0) begin
            $display("FAIL reset_state: op=%h busy=%b fin=%b in_cycle=%0d data=%h, want all zero",
                     op, busy, finished, in_cycle, in_staging);
            miscompares++;
        end
        cfg_write(0, 0, 1, 0, 1'b1);
        cfg_write(1, 0, 0, 0, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < N; i++) begin ob[i] = $urandom | 32'h1; oc[i] = $urandom | 32'h1; end
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        clear_model();
        vectors++;
        if (op !== '0 || busy !== 1'b0 || finished !== 1'b0 || in_cycle !== '0 || in_staging !== '0 || in_cr_staging !== '0) begin
            $display("FAIL midrun_reset: op=%h busy=%b fin=%b in_cycle=%0d data=%h cr=%h, want all zero",
                     op, busy, finished, in_cycle, in_staging, in_cr_staging);
            miscompares++;
        end
        run(1, -1, -1, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_ring();
        int c;
        cfg_write(0, 0, 1, 0, 1'b1);
        cfg_write(1, 0, 0, 0, 1'b1);
        for (int i = 0; i < N; i++) begin ob[i] = '0; oc[i] = '0; end
        ob[0] = 32'hA5; ob[2] = 32'h5A; oc[0] = 32'h11; oc[2] = 32'h22;
        run(1, -1, -1, 0, 1'b0, 1'b0, c);
        vectors++;
        if (in_staging[2*W +: W] !== 32'hA5 || in_staging[0 +: W] !== 32'h5A ||
            in_cr_staging[0 +: W] !== 32'h22 || in_cr_staging[2*W +: W] !== 32'h11) begin
            $display("FAIL ring: data=%h cr=%h, want r1=a5 r0=5a cr r0=22 r1=11", in_staging, in_cr_staging);
            miscompares++;
        end
    endtask

    task automatic test_cycle_limit();
        int c;
        run(3, -1, -1, 0, 1'b1, 1'b0, c);
        vectors++;
        if (c !== 10 || in_cycle !== 16'd3) begin
            $display("FAIL cycle_limit: finished after %0d clocks in_cycle=%0d, want 10 clocks in_cycle=3", c, in_cycle);
            miscompares++;
        end
    endtask

    task automatic test_done_stop();
        int c;
        run(0, 1, -1, 0, 1'b1, 1'b0, c);
        vectors++;
        if (in_cycle !== 16'd2) begin
            $display("FAIL done_term: in_cycle=%0d, want 2", in_cycle);
            miscompares++;
        end
        run(0, -1, 2, 1, 1'b1, 1'b0, c);
        run(0, -1, 1, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_collision();
        int c;
        cfg_write(0, 0, 1, 1, 1'b1);
        cfg_write(1, 0, 1, 1, 1'b1);
        for (int i = 0; i < N; i++) begin ob[i] = '0; oc[i] = '0; end
        ob[0] = 32'h01; ob[2] = 32'h02;
        run(1, -1, -1, 0, 1'b0, 1'b0, c);
        vectors++;
        if (in_staging[3*W +: W] !== 32'h02 || in_staging[2*W +: W] !== 32'h0) begin
            $display("FAIL collision: in[1][1]=%h in[1][0]=%h, want 02 and 00", in_staging[3*W +: W], in_staging[2*W +: W]);
            miscompares++;
        end
    endtask

    task automatic test_cfg_busy();
        int c;
        run(2, -1, -1, 0, 1'b1, 1'b1, c);
        cfg_write(0, 0, 0, 1, 1'b1);
        run(1, -1, -1, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_random();
        int c;
        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < N; s++)
                cfg_write(s / P, s % P, $urandom_range(0, R - 1), $urandom_range(0, P - 1), 1'($urandom));
            run($urandom_range(0, 4), $urandom_range(0, 5) - 1, $urandom_range(0, 5) - 1,
                $urandom_range(0, 1), 1'b1, 1'b0, c);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin ob[i] = '0; oc[i] = '0; end
        clear_model();
        tick(); tick();
        rst = 1'b0;
        test_reset();
        test_ring();
        test_cycle_limit();
        test_done_stop();
        test_collision();
        test_cfg_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/noc_phase_sequencer.md
# noc_phase_sequencer

Synthesizable, parametrised network-level sequencer for the NoC simulation fabric. It holds a programmable link table that maps each (router, port) output to a destination (router, port). It steps all routers in lock-step through a LOAD_STAGING step followed by PHASES compute phases per network cycle, and moves data flits forward and credit flits backward across links. It terminates on all-routers-done, a cycle limit, or an external stop.

## Interface
Parameters:
- NUM_ROUTERS, 4, number of routers (R); index width RB = clog2(R), min 1
- NUM_PORTS, 4, ports per router (P); index width PB = clog2(P), min 1
- FLIT_W, 32, data/credit flit width
- OP_W, 3, router op code width
- PHASES, 2, compute phases per network cycle (1..2^OP_W-2)
- CYCLE_W, 32, in_cycle counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run (honoured in IDLE/DONE)
- stop  in  1  request termination at end of current network cycle
- max_cycles  in  CYCLE_W  cycle limit; 0 = unlimited
- cfg_we  in  1  link-table write strobe
- cfg_src_router  in  RB  source router
- cfg_src_port  in  PB  source port
- cfg_dst_router  in  RB  destination router
- cfg_dst_port  in  PB  destination port
- cfg_valid  in  1  link valid bit to write
- router_done  in  R  per-router done flags
- out_staging  in  R*P*FLIT_W  router output data flits, flat [r][p]
- out_cr_staging  in  R*P*FLIT_W  router output credit flits, flat [r][p]
- op  out  R*OP_W  per-router op code
- in_staging  out  R*P*FLIT_W  router input data flits
- in_cr_staging  out  R*P*FLIT_W  router input credit flits
- in_cycle  out  CYCLE_W  completed network cycles
- busy  out  1  high in LOAD/PHASE states
- finished  out  1  high in DONE

## Operation
- States: IDLE, LOAD, PHASE_k (k=0..PHASES-1), DONE.
- op encoding: NOP=0 (IDLE/DONE), LOAD_STAGING=1, PHASE_k=2+k. op is the same for all routers and is decoded from the current state.
- IDLE --start--> LOAD -> PHASE_0 -> ... -> PHASE_{PHASES-1} -> LOAD, or -> DONE on termination.
- On the edge leaving LOAD:
  - For every valid entry (r,p)->(dr,dp): in_staging[dr][dp] <= out_staging[r][p] and in_cr_staging[r][p] <= out_cr_staging[dr][dp].
  - Destinations with no valid source receive 0.
  - Credit inputs of source ports with an invalid entry receive 0.
- Collision (two sources, one destination): the highest flat index r*P+p wins.
- On the edge leaving PHASE_{PHASES-1}, in_cycle increments (wraps at 2^CYCLE_W). Go to DONE if any of:
  - &router_done sampled in that cycle
  - max_cycles!=0 and in_cycle+1 == max_cycles
  - stop seen (latched) at any time since the last LOAD
  Otherwise go to LOAD.
- DONE --start--> LOAD. The start edge clears in_cycle and the stop latch. Staging registers are retained.
- cfg_we is honoured only in IDLE/DONE and ignored while busy. A write takes effect on the next edge.
- start while busy is ignored.
- rst (any state, including mid-run):
  - state=IDLE; op=0, in_staging=0, in_cr_staging=0, in_cycle=0, busy=0, finished=0
  - all link entries invalid; stop latch cleared

## Timing
- Network cycle period = PHASES+1 clocks.
- start high at edge t: LOAD during t+1, PHASE_0 during t+2, and so on.
- in_staging/in_cr_staging are valid from the first PHASE_0 clock and stable until the next LOAD ends.
- in_cycle updates at the same edge that enters LOAD or DONE.
- busy/finished/op are registered-state decodes; no combinational path from inputs.
- stop asserted during the final phase terminates that same network cycle.

## Test plan
- Reset: drive rst mid-PHASE_0 with PHASES=2 -> next clock op=0, in_cycle=0, busy=0, in_staging=0. A run with no reprogramming moves no data.
- Ring R=2,P=1, links (0,0)->(1,0), (1,0)->(0,0); out_staging r0=0xA5, r1=0x5A; out_cr r0=0x11, r1=0x22 -> after LOAD: in_staging r1=0xA5, r0=0x5A; in_cr r0=0x22, r1=0x11.
- Cycle limit max_cycles=3, PHASES=2, router_done=0 -> op sequence 1,2,3 repeated 3×. finished high at clock 10 after start. in_cycle=3.
- Done termination: router_done all-ones during 2nd network cycle's last phase -> DONE with in_cycle=2. A partial done mask does not terminate.
- Collision: (0,0)->(1,1) and (1,0)->(1,1), data 0x01/0x02 -> in_staging[1][1]=0x02. in_staging[1][0]=0.
- Config while busy: cfg_we during PHASE_0 remapping a link -> routing unchanged. The same write in DONE followed by start -> new mapping used, in_cycle restarts at 0.
